// File: rtl/reception_checker_pkg.sv
// reception_checker_pkg: state encoding and pattern constant shared by the FT245 test generator and checker
package reception_checker_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, SYNC = 3'd1, CHECK = 3'd2, STALL = 3'd3, DONE = 3'd4} state_t;
  localparam int unsigned PAT_INC = 1;
  function automatic logic is_run(state_t s);
    return s inside {SYNC, CHECK, STALL};
  endfunction
endpackage

// File: rtl/reception_checker_if.sv
// reception_checker_if: first-word-fall-through RX FIFO read port (FIFO is master, checker is slave)
interface reception_checker_if #(parameter int DATA_W = 32);
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_read;
  modport master (output rx_valid, rx_data, input rx_read);
  modport slave  (input rx_valid, rx_data, output rx_read);
endinterface

// File: rtl/reception_checker_btn_sync_edge.sv
// btn_sync_edge: 2-FF synchroniser for a raw button plus a one-cycle rising-edge pulse
module btn_sync_edge (
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_btn,
  output logic o_pulse
);
  logic [2:0] r_sync;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) r_sync <= '0;
    else r_sync <= {r_sync[1:0], i_btn};
  assign o_pulse = r_sync[1] & ~r_sync[2];
endmodule

// File: rtl/reception_checker.sv
// reception_checker: drains the FT245 RX FIFO and checks an incrementing-counter pattern.
// Optional RX_CHECK_FIRST_ERR_EN adds first_err_data/first_err_exp capture of the first mismatch.
module reception_checker
  import reception_checker_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 32,
  parameter int ERR_W       = 16,
  parameter int MAX_WORDS   = 0,
  parameter int TIMEOUT_CYC = 80_000_000
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                trigger,
  reception_checker_if.slave  rx,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [CNT_W-1:0]    word_cnt,
  output logic [ERR_W-1:0]    err_cnt
`ifdef RX_CHECK_FIRST_ERR_EN
  ,
  output logic [DATA_W-1:0]   first_err_data,
  output logic [DATA_W-1:0]   first_err_exp
`endif
);
  localparam int TMR_W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  state_t             r_state, w_state_nxt;
  logic [DATA_W-1:0]  r_exp;
  logic [TMR_W-1:0]   r_tmr;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_edge, w_run, w_pop, w_err, w_last, w_tmo;
  btn_sync_edge u_trig (.clk_in(clk_in), .rst_in(rst_in), .i_btn(trigger), .o_pulse(w_edge));
  assign w_run      = is_run(r_state);
  // a trigger edge suppresses the pop so the word stays for the new run
  assign w_pop      = rx.rx_valid && w_run && !w_edge;
  assign w_err      = w_pop && r_state != SYNC && rx.rx_data != r_exp;
  assign w_cnt_inc  = r_state == SYNC ? CNT_W'(1) : word_cnt + CNT_W'(~&word_cnt);
  assign w_last     = MAX_WORDS != 0 && w_cnt_inc == CNT_W'(MAX_WORDS);
  assign w_tmo      = r_state == CHECK && !w_pop && r_tmr == TMR_W'(TIMEOUT_CYC - 1);
  assign rx.rx_read = w_pop;
  assign busy       = w_run;
  assign done       = r_state == DONE;
  assign pass       = done && err_cnt == '0;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_edge ? SYNC : w_pop ? (w_last ? DONE : CHECK) : w_tmo ? STALL : r_state;
  end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      word_cnt <= '0;
      err_cnt  <= '0;
      timeout  <= 1'b0;
      r_exp    <= '0;
      r_tmr    <= '0;
    end else if (w_edge) begin
      word_cnt <= '0;
      err_cnt  <= '0;
      timeout  <= 1'b0;
      r_tmr    <= '0;
    end else begin
      if (w_pop) word_cnt <= w_cnt_inc;
      // match or mismatch, the next expected word always follows the one just popped
      if (w_pop) r_exp <= rx.rx_data + DATA_W'(PAT_INC);
      if (w_err) err_cnt <= err_cnt + ERR_W'(~&err_cnt);
      if (w_tmo) timeout <= 1'b1;
      r_tmr <= (w_pop || r_state != CHECK) ? '0 : r_tmr + TMR_W'(1);
    end
`ifdef RX_CHECK_FIRST_ERR_EN
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      first_err_data <= '0;
      first_err_exp  <= '0;
    end else if (w_edge) begin
      first_err_data <= '0;
      first_err_exp  <= '0;
    end else if (w_err && err_cnt == '0) begin
      first_err_data <= rx.rx_data;
      first_err_exp  <= r_exp;
    end
`endif
endmodule

// File: tb/tb_reception_checker.sv
// tb_reception_checker: directed and randomized checks of reception_checker against a pattern-rule model
module tb_reception_checker;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        trigger = 1'b0;
  logic        busy, done, pass, timeout;
  logic [31:0] word_cnt;
  logic [15:0] err_cnt;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_words, n_errs;
  logic [31:0] q[$];
  logic [31:0] prev;
  int          r;
`ifdef RX_CHECK_FIRST_ERR_EN
  logic [31:0] fe_data, fe_exp;
`endif
  reception_checker_if #(.DATA_W(32)) rx_if ();
  reception_checker #(.DATA_W(32), .CNT_W(32), .ERR_W(16), .MAX_WORDS(100), .TIMEOUT_CYC(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .trigger(trigger), .rx(rx_if.slave),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .word_cnt(word_cnt), .err_cnt(err_cnt)
`ifdef RX_CHECK_FIRST_ERR_EN
    , .first_err_data(fe_data), .first_err_exp(fe_exp)
`endif
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [31:0] w, input int gap);
    rx_if.rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk_in);
      #1;
    end
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = w;
    #1 chk("pop", {31'd0, rx_if.rx_read}, 32'd1);
    @(posedge clk_in);
    #1 rx_if.rx_valid = 1'b0;
  endtask
  task automatic trig();
    trigger = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 trigger = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
  endtask
  initial begin
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = 32'h1234;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_word_cnt", word_cnt, 32'd0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("rst_rx_read", {31'd0, rx_if.rx_read}, 32'd0);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 chk("idle_no_pop", {31'd0, rx_if.rx_read}, 32'd0);
    chk("idle_word_cnt", word_cnt, 32'd0);
    rx_if.rx_valid = 1'b0;
    // 100 back-to-back words reach DONE with pass
    trig();
    chk("a_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 100; i++) send(32'(i), 0);
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = 32'd100;
    #1 chk("a_done_no_pop", {31'd0, rx_if.rx_read}, 32'd0);
    chk("a_done", {31'd0, done}, 32'd1);
    chk("a_pass", {31'd0, pass}, 32'd1);
    chk("a_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("a_word_cnt", word_cnt, 32'd100);
    chk("a_busy_off", {31'd0, busy}, 32'd0);
    rx_if.rx_valid = 1'b0;
    // one dropped word costs one error
    trig();
    chk("b_done_clr", {31'd0, done}, 32'd0);
    chk("b_word_clr", word_cnt, 32'd0);
    for (int i = 0; i < 10; i++) if (i != 5) send(32'(i), 0);
    chk("b_err_cnt", {16'd0, err_cnt}, 32'd1);
    chk("b_word_cnt", word_cnt, 32'd9);
    chk("b_pass", {31'd0, pass}, 32'd0);
`ifdef RX_CHECK_FIRST_ERR_EN
    chk("b_first_err_data", fe_data, 32'd6);
    chk("b_first_err_exp", fe_exp, 32'd5);
`endif
    // counter wrap is accepted
    trig();
    chk("c_err_clr", {16'd0, err_cnt}, 32'd0);
    send(32'hFFFF_FFFE, 0);
    send(32'hFFFF_FFFF, 0);
    send(32'h0, 0);
    send(32'h1, 0);
    chk("c_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("c_word_cnt", word_cnt, 32'd4);
    // 16 idle cycles in CHECK set the stall flag
    repeat (15) @(posedge clk_in);
    #1 chk("d_timeout_early", {31'd0, timeout}, 32'd0);
    @(posedge clk_in);
    #1 chk("d_timeout", {31'd0, timeout}, 32'd1);
    chk("d_busy", {31'd0, busy}, 32'd1);
    send(32'h2, 0);
    chk("d_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("d_word_cnt", word_cnt, 32'd5);
    chk("d_timeout_sticky", {31'd0, timeout}, 32'd1);
    // trigger edge coinciding with a valid word: the trigger wins
    trigger = 1'b1;
    send(32'h3, 0);
    send(32'h4, 0);
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = 32'h5;
    #1 chk("e_no_pop", {31'd0, rx_if.rx_read}, 32'd0);
    @(posedge clk_in);
    #1 chk("e_word_clr", word_cnt, 32'd0);
    chk("e_err_clr", {16'd0, err_cnt}, 32'd0);
    chk("e_timeout_clr", {31'd0, timeout}, 32'd0);
    chk("e_busy", {31'd0, busy}, 32'd1);
    trigger = 1'b0;
    send(32'd70, 0);
    send(32'd71, 0);
    chk("e_word_cnt", word_cnt, 32'd2);
    chk("e_err_cnt", {16'd0, err_cnt}, 32'd0);
    repeat (2) @(posedge clk_in);
    #1;
    // randomized runs: errors are the adjacent pairs that do not increment by one
    for (int run = 0; run < 6; run++) begin
      q.delete();
      n_words = $urandom_range(10, 80);
      prev = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 20)) : 32'($urandom());
      for (int i = 0; i < n_words; i++) begin
        if (i > 0) begin
          r = $urandom_range(0, 9);
          prev = r < 7 ? prev + 32'd1 : r < 9 ? prev + 32'($urandom_range(2, 5)) : 32'($urandom());
        end
        q.push_back(prev);
      end
      n_errs = 0;
      for (int i = 1; i < n_words; i++) if (q[i] != q[i-1] + 32'd1) n_errs++;
      trig();
      foreach (q[i]) send(q[i], $urandom_range(0, 4));
      chk("rnd_word_cnt", word_cnt, 32'(n_words));
      chk("rnd_err_cnt", {16'd0, err_cnt}, 32'(n_errs));
      chk("rnd_timeout", {31'd0, timeout}, 32'd0);
      chk("rnd_done", {31'd0, done}, 32'd0);
    end
    // reset mid-run returns to IDLE immediately
    trig();
    send(32'd10, 0);
    send(32'd11, 0);
    rx_if.rx_valid = 1'b1;
    #2 rst_in = 1'b0;
    #1 chk("f_word_cnt", word_cnt, 32'd0);
    chk("f_busy", {31'd0, busy}, 32'd0);
    chk("f_rx_read", {31'd0, rx_if.rx_read}, 32'd0);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 chk("f_idle_no_pop", {31'd0, rx_if.rx_read}, 32'd0);
    chk("f_idle_word_cnt", word_cnt, 32'd0);
    rx_if.rx_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
